circular_buffer: RTL and testbench

CIRCULAR_BUFFER -- requirements
Module: circular_buffer

---
 rtl/params_noc.sv | 35 +++
 rtl/circular_buffer.sv | 74 +++++++
 tb/tb_circular_buffer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/params_noc.sv
// Shared NoC flit definitions: label enum, head-flit layout and the flit type
// stored by the circular buffer.
package params_noc;

    localparam int x_Des_Addr_Size    = 4;
    localparam int y_Des_Addr_Size    = 4;
    localparam int header_Payloadsize = 24;

    // Width of the data part of a flit; head and body views share it.
    localparam int flit_Data_Width = x_Des_Addr_Size + y_Des_Addr_Size + header_Payloadsize;

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        TAIL,
        HEADTAIL
    } flit_Data_Label;

    typedef struct packed {
        logic [x_Des_Addr_Size-1:0]    x_Dest;
        logic [y_Des_Addr_Size-1:0]    y_Dest;
        logic [header_Payloadsize-1:0] head_Payload;
    } head_Data;

    typedef union packed {
        head_Data                   header;
        logic [flit_Data_Width-1:0] payload;
    } flit_Data_Union;

    typedef struct packed {
        flit_Data_Label flit_Label;
        flit_Data_Union data;
    } flit_Data_noVC;

endpackage

// File: rtl/circular_buffer.sv
// First-word-fall-through flit FIFO with registered occupancy and on/off
// flow control toward the upstream sender.
module circular_buffer
    import params_noc::*;
#(
    parameter int unsigned BUFFER_SIZE      = 8,
    parameter int unsigned ON_OFF_THRESHOLD = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  flit_Data_noVC input_Data,
    input  logic          write_i,
    input  logic          read_i,
    output flit_Data_noVC output_Data,
    output logic          buf_empty,
    output logic          buf_full,
    output logic          buf_On_Off
);

    localparam int unsigned PtrW = $clog2(BUFFER_SIZE);
    localparam int unsigned CntW = PtrW + 1;

    flit_Data_noVC   r_mem [BUFFER_SIZE];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;

    logic            w_rd_en;
    logic            w_wr_en;
    logic [CntW-1:0] w_count_nxt;
    logic [CntW-1:0] w_free;

    // Status is decoded from the registered occupancy only.
    assign buf_empty  = (r_count == '0);
    assign buf_full   = (r_count == CntW'(BUFFER_SIZE));
    assign w_free     = CntW'(BUFFER_SIZE) - r_count;
    assign buf_On_Off = (32'(w_free) > ON_OFF_THRESHOLD);

    // A pop frees a slot in the same edge, so a write into a full buffer is
    // legal when accompanied by a granted read.
    assign w_rd_en = read_i & ~buf_empty;
    assign w_wr_en = write_i & (~buf_full | w_rd_en);

    assign output_Data = buf_empty ? '0 : r_mem[r_rd_ptr];

    // Next occupancy from the granted read/write pair.
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_en, w_rd_en})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    // Flit storage; no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= input_Data;
    end

endmodule

// File: tb/tb_circular_buffer.sv
// Directed, table-driven bench for circular_buffer plus hand-written sequences
// for reset and a short randomized mix against a reference queue.
module tb_circular_buffer;
    import params_noc::*;

    logic          clk;
    logic          rst_n;
    flit_Data_noVC input_Data;
    logic          write_i;
    logic          read_i;
    flit_Data_noVC output_Data;
    logic          buf_empty;
    logic          buf_full;
    logic          buf_On_Off;

    circular_buffer #(
        .BUFFER_SIZE      (8),
        .ON_OFF_THRESHOLD (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_Data  (input_Data),
        .write_i     (write_i),
        .read_i      (read_i),
        .output_Data (output_Data),
        .buf_empty   (buf_empty),
        .buf_full    (buf_full),
        .buf_On_Off  (buf_On_Off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic          rd;
        flit_Data_noVC din;
        flit_Data_noVC exp_out;
        logic          exp_empty;
        logic          exp_full;
        logic          exp_on;
        string         name;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic flit_Data_noVC mk(flit_Data_Label l, logic [31:0] d);
        flit_Data_noVC f;
        f.flit_Label   = l;
        f.data.payload = d;
        return f;
    endfunction

    function automatic flit_Data_noVC body(int n);
        return mk(BODY, 32'h0000_0100 + 32'(n));
    endfunction

    function automatic flit_Data_noVC efl(int n);
        return mk(TAIL, 32'hE000_0000 + 32'(n));
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(logic wr, logic rd, flit_Data_noVC din, flit_Data_noVC eo,
                       logic ee, logic ef, logic eon, string name);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.exp_out = eo;
        v.exp_empty = ee; v.exp_full = ef; v.exp_on = eon; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check_status(string name, flit_Data_noVC eo, logic ee, logic ef, logic eon);
        chk({name, ".out"},   64'(output_Data), 64'(eo));
        chk({name, ".empty"}, 64'(buf_empty),   64'(ee));
        chk({name, ".full"},  64'(buf_full),    64'(ef));
        chk({name, ".onoff"}, 64'(buf_On_Off),  64'(eon));
    endtask

    flit_Data_noVC zero_f;
    flit_Data_noVC head_f;
    flit_Data_noVC b_f;
    flit_Data_noVC x_f;
    flit_Data_noVC q[$];

    initial begin
        zero_f = '0;
        head_f = mk(HEAD, 32'h1000_00AA);  // x_Dest=1, y_Dest=0, payload 0xAA
        b_f    = mk(BODY, 32'h0000_B0D1);
        x_f    = mk(HEADTAIL, 32'h1234_5678);

        // Single HEAD flit in and out, then a read on empty.
        add(1, 0, head_f, head_f, 0, 0, 1, "head_wr");
        add(0, 1, zero_f, zero_f, 1, 0, 1, "head_rd");
        add(0, 1, zero_f, zero_f, 1, 0, 1, "rd_empty");
        // Fill 8: on/off drops at 6 stored (2 free), full at 8.
        for (int k = 0; k < 8; k++)
            add(1, 0, body(k), body(0), 0, (k == 7), (k + 1 <= 5), $sformatf("fill%0d", k));
        add(1, 0, body(99), body(0), 0, 1, 0, "wr_full_ign");
        // Drain 8 in order; on/off returns once 3+ slots are free.
        for (int j = 0; j < 8; j++)
            add(0, 1, zero_f, (j < 7) ? body(j + 1) : zero_f, (j == 7), 0, (j >= 2),
                $sformatf("drain%0d", j));
        // Refill, then read+write while full for 4 cycles.
        for (int k = 0; k < 8; k++)
            add(1, 0, efl(k), efl(0), 0, (k == 7), (k + 1 <= 5), $sformatf("refill%0d", k));
        for (int i = 0; i < 4; i++)
            add(1, 1, efl(8 + i), efl(i + 1), 0, 1, 0, $sformatf("rw_full%0d", i));
        for (int j = 0; j < 8; j++)
            add(0, 1, zero_f, (j < 7) ? efl(5 + j) : zero_f, (j == 7), 0, (j >= 2),
                $sformatf("wrap_rd%0d", j));
        // Read+write on empty: only the write happens.
        add(1, 1, b_f, b_f, 0, 0, 1, "rw_empty");
        add(0, 1, zero_f, zero_f, 1, 0, 1, "rw_empty_rd");
        add(0, 1, zero_f, zero_f, 1, 0, 1, "rd_empty2");

        rst_n = 1'b0; write_i = 1'b0; read_i = 1'b0; input_Data = '0;
        #1;
        check_status("in_reset", zero_f, 1, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_status("post_reset", zero_f, 1, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            write_i = vecs[i].wr; read_i = vecs[i].rd; input_Data = vecs[i].din;
            @(posedge clk); #1;
            check_status(vecs[i].name, vecs[i].exp_out, vecs[i].exp_empty,
                         vecs[i].exp_full, vecs[i].exp_on);
        end

        // Fill up, then assert reset between edges: must clear at once.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            write_i = 1'b1; read_i = 1'b0; input_Data = body(k);
        end
        @(negedge clk);
        write_i = 1'b0;
        chk("pre_rst.full", 64'(buf_full), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_status("async_rst", zero_f, 1, 0, 1);
        @(negedge clk);
        rst_n = 1'b1; write_i = 1'b1; input_Data = x_f;
        @(posedge clk); #1;
        check_status("first_wr", x_f, 0, 0, 1);

        // Short random mix against a reference queue (starts holding x_f).
        q = {x_f};
        for (int s = 0; s < 5; s++) begin
            logic wr, rd, rd_ok, wr_ok;
            flit_Data_noVC d;
            @(negedge clk);
            wr = 1'($urandom_range(0, 1));
            rd = (s == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            d  = mk(flit_Data_Label'($urandom_range(0, 3)), $urandom);
            write_i = wr; read_i = rd; input_Data = d;
            chk($sformatf("mix%0d.front", s), 64'(output_Data),
                64'((q.size() > 0) ? q[0] : zero_f));
            chk($sformatf("mix%0d.empty", s), 64'(buf_empty), 64'(q.size() == 0));
            rd_ok = rd && (q.size() > 0);
            wr_ok = wr && ((q.size() < 8) || rd_ok);
            @(posedge clk);
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(d);
        end
        @(negedge clk);
        write_i = 1'b0; read_i = 1'b0;
        chk("mix_end.front", 64'(output_Data), 64'((q.size() > 0) ? q[0] : zero_f));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
